axi4aw_chk_fifo: RTL and testbench

//   Parametrised AXI4 write-address (AW) channel buffer with an inline protocol checker.
//   - Sits between an AW master (core/DMA) and the interconnect or slave.
//   - Decouples the two sides with a DEPTH-entry FIFO.
//   - Flags illegal AW requests; flagged requests are still forwarded unchanged.

---
 rtl/axi4aw_chk_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_axi4aw_chk_fifo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4aw_chk_fifo.sv
// Purpose  : AXI4 write-address (AW) channel buffer with an inline protocol checker.
//            Illegal requests raise sticky err bits but are forwarded unchanged.
// Latency  : an entry pushed at edge N is presented downstream in cycle N+1. There is no same-cycle bypass.
// Backpress: s_awready = !rst && count<DEPTH, taken from registered state only.
//            A pop never frees a slot for a push in the same cycle.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   s_aw* / s_awvalid    upstream AW payload and valid; s_awready = not full
//   m_aw* / m_awvalid    downstream AW payload (zero when empty) and valid; m_awready from downstream
//   count                current FIFO occupancy
//   err                  sticky flags: [0] 4KB cross, [1] bad WRAP, [2] size > bus, [3] bad burst/len
//   err_clr              clears all err bits at the next edge. A new violation in the same cycle wins.

module axi4aw_chk_fifo #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [ID_W-1:0]          s_awid,
    input  logic [ADDR_W-1:0]        s_awaddr,
    input  logic [7:0]               s_awlen,
    input  logic [2:0]               s_awsize,
    input  logic [1:0]               s_awburst,
    input  logic                     s_awlock,
    input  logic [3:0]               s_awcache,
    input  logic [2:0]               s_awprot,
    input  logic [3:0]               s_awregion,
    input  logic [3:0]               s_awqos,
    input  logic                     s_awvalid,
    output logic                     s_awready,

    output logic [ID_W-1:0]          m_awid,
    output logic [ADDR_W-1:0]        m_awaddr,
    output logic [7:0]               m_awlen,
    output logic [2:0]               m_awsize,
    output logic [1:0]               m_awburst,
    output logic                     m_awlock,
    output logic [3:0]               m_awcache,
    output logic [2:0]               m_awprot,
    output logic [3:0]               m_awregion,
    output logic [3:0]               m_awqos,
    output logic                     m_awvalid,
    input  logic                     m_awready,

    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               err,
    input  logic                     err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        region;
        logic [3:0]        qos;
    } aw_t;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    aw_t            mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;
    logic [3:0]     err_q,    err_d;

    aw_t            s_pkt;
    aw_t            head;
    logic           push;
    logic           pop;

    assign s_pkt = '{
        id:     s_awid,
        addr:   s_awaddr,
        len:    s_awlen,
        size:   s_awsize,
        burst:  s_awburst,
        lock:   s_awlock,
        cache:  s_awcache,
        prot:   s_awprot,
        region: s_awregion,
        qos:    s_awqos
    };

    // count is the only source of full/empty.
    // Ready depends only on rst and registered count. It never depends on m_awready.
    assign s_awready = !rst && (count_q < CW'(DEPTH));
    assign m_awvalid = (count_q != '0);

    assign push = s_awvalid && s_awready;
    assign pop  = m_awvalid && m_awready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset. Stale entries are never visible because the output is masked by m_awvalid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_pkt;
        end
    end

    // First-word-fall-through head. The payload is forced to zero whenever nothing is valid.
    assign head = m_awvalid ? mem_q[rd_ptr_q] : '0;

    assign m_awid     = head.id;
    assign m_awaddr   = head.addr;
    assign m_awlen    = head.len;
    assign m_awsize   = head.size;
    assign m_awburst  = head.burst;
    assign m_awlock   = head.lock;
    assign m_awcache  = head.cache;
    assign m_awprot   = head.prot;
    assign m_awregion = head.region;
    assign m_awqos    = head.qos;

    assign count = count_q;

    // ------------------------------------------------------------------
    // Protocol checker
    // The checker looks at the upstream payload and only matters on a push.
    // ------------------------------------------------------------------
    logic [15:0] burst_bytes;   // (len+1) << size, max 256*128 = 32768
    logic [7:0]  beat_bytes;    // 1 << size
    logic        len_wrap_ok;
    logic        addr_aligned;
    logic [3:0]  viol;

    assign burst_bytes  = (16'(s_awlen) + 16'd1) << s_awsize;
    assign beat_bytes   = 8'd1 << s_awsize;
    assign len_wrap_ok  = (s_awlen == 8'd1) || (s_awlen == 8'd3) ||
                          (s_awlen == 8'd7) || (s_awlen == 8'd15);
    assign addr_aligned = ((s_awaddr[6:0] & 7'(beat_bytes - 8'd1)) == 7'd0);

    always_comb begin
        viol = 4'b0000;
        // The page of the last byte differs from the page of addr exactly when
        // offset-in-page + burst_bytes runs past 4096.
        // The carry into the page number is at most 8, so that number can never wrap back onto itself.
        // The check therefore also covers bursts that run off the top of the address space.
        viol[0] = (s_awburst == BURST_INCR) &&
                  ((17'(s_awaddr[11:0]) + 17'(burst_bytes)) > 17'd4096);
        viol[1] = (s_awburst == BURST_WRAP) && (!len_wrap_ok || !addr_aligned);
        viol[2] = 32'(beat_bytes) > 32'(DATA_W / 8);
        viol[3] = (s_awburst == BURST_RSVD) ||
                  ((s_awburst == BURST_FIXED) && (s_awlen > 8'd15));
    end

    // A new violation wins over err_clr bit by bit. All other bits are cleared.
    assign err_d = (err_clr ? 4'b0000 : err_q) | (push ? viol : 4'b0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 4'b0000;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_axi4aw_chk_fifo.sv
// Purpose  : directed and randomized bench for axi4aw_chk_fifo with a queue-based reference model.
// Latency  : outputs are checked each cycle at the falling edge. The model advances after each rising edge.
// Backpress: the model decides push/pop from its own occupancy and never reads DUT state.

module tb_axi4aw_chk_fifo;

    localparam int ID_W   = 1;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int PLW    = ID_W + ADDR_W + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ID_W-1:0]   s_awid = '0;
    logic [ADDR_W-1:0] s_awaddr = '0;
    logic [7:0]        s_awlen = '0;
    logic [2:0]        s_awsize = '0;
    logic [1:0]        s_awburst = '0;
    logic              s_awlock = '0;
    logic [3:0]        s_awcache = '0;
    logic [2:0]        s_awprot = '0;
    logic [3:0]        s_awregion = '0;
    logic [3:0]        s_awqos = '0;
    logic              s_awvalid = 1'b0;
    logic              s_awready;
    logic [ID_W-1:0]   m_awid;
    logic [ADDR_W-1:0] m_awaddr;
    logic [7:0]        m_awlen;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_awlock;
    logic [3:0]        m_awcache;
    logic [2:0]        m_awprot;
    logic [3:0]        m_awregion;
    logic [3:0]        m_awqos;
    logic              m_awvalid;
    logic              m_awready = 1'b0;
    logic [$clog2(DEPTH):0] count;
    logic [3:0]        err;
    logic              err_clr = 1'b0;

    always #5 clk = ~clk;

    axi4aw_chk_fifo #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awregion(s_awregion), .s_awqos(s_awqos), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awregion(m_awregion), .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .count(count), .err(err), .err_clr(err_clr)
    );

    wire [PLW-1:0] s_pl = {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
                           s_awlock, s_awcache, s_awprot, s_awregion, s_awqos};
    wire [PLW-1:0] m_pl = {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
                           m_awlock, m_awcache, m_awprot, m_awregion, m_awqos};

    // Reference model: an ordered list of accepted requests plus sticky flags.
    logic [PLW-1:0] model_q[$];
    logic [3:0]     err_m = 4'b0000;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the AXI4 rules directly with integer arithmetic.
    function automatic logic [3:0] rules(input longint unsigned addr, input int len,
                                         input int size, input int burst);
        longint unsigned nbytes, last, page_mask;
        int beat;
        logic [3:0] e;
        beat      = 1 << size;
        nbytes    = longint'(len + 1) * longint'(beat);
        last      = addr + nbytes - 1;
        page_mask = (64'd1 << (ADDR_W - 12)) - 1;
        e[0] = (burst == 1) && ((addr >> 12) != ((last >> 12) & page_mask));
        e[1] = (burst == 2) && (!(len == 1 || len == 3 || len == 7 || len == 15) ||
                                (addr % longint'(beat)) != 0);
        e[2] = beat > DATA_W / 8;
        e[3] = (burst == 3) || (burst == 0 && len > 15);
        return e;
    endfunction

    // One clock cycle:
    //   1. check the outputs at the falling edge;
    //   2. predict push/pop from the model;
    //   3. update the model just after the rising edge.
    task automatic cycle();
        logic do_push, do_pop;
        logic [3:0] v;
        logic [PLW-1:0] pl;
        @(negedge clk);
        chk("m_awvalid", 128'(m_awvalid), 128'(model_q.size() != 0));
        chk("m_payload", 128'(m_pl), model_q.size() != 0 ? 128'(model_q[0]) : 128'(0));
        chk("s_awready", 128'(s_awready), 128'(!rst && model_q.size() < DEPTH));
        chk("count", 128'(count), 128'(model_q.size()));
        chk("err", 128'(err), 128'(err_m));
        do_push = s_awvalid && !rst && (model_q.size() < DEPTH);
        do_pop  = m_awready && !rst && (model_q.size() != 0);
        v  = rules(longint'(s_awaddr), int'(s_awlen), int'(s_awsize), int'(s_awburst));
        pl = s_pl;
        @(posedge clk);
        #1;
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(pl);
        err_m = (err_clr ? 4'b0000 : err_m) | (do_push ? v : 4'b0000);
    endtask

    task automatic set_aw(input int id, input logic [ADDR_W-1:0] addr, input int len,
                          input int size, input int burst);
        s_awid     = ID_W'(id);
        s_awaddr   = addr;
        s_awlen    = 8'(len);
        s_awsize   = 3'(size);
        s_awburst  = 2'(burst);
        s_awlock   = 1'($urandom);
        s_awcache  = 4'($urandom);
        s_awprot   = 3'($urandom);
        s_awregion = 4'($urandom);
        s_awqos    = 4'($urandom);
    endtask

    task automatic drain();
        s_awvalid = 1'b0;
        m_awready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        m_awready = 1'b0;
    endtask

    initial begin
        // Reset state, checked while rst is held.
        #2;
        chk("rst_s_awready", 128'(s_awready), 128'(0));
        chk("rst_m_awvalid", 128'(m_awvalid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        cycle();
        rst = 1'b0;

        // Fill to full with m_awready low, then hold valid while full, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            set_aw(i, ADDR_W'(($urandom % 1024) * 4), 0, 2, 1);
            s_awvalid = 1'b1;
            cycle();
        end
        set_aw(1, 32'h100, 0, 2, 1);
        cycle();
        cycle();
        s_awvalid = 1'b0;
        m_awready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();

        // Steady state at count=2 with simultaneous push and pop.
        m_awready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_aw(i, ADDR_W'($urandom % 256) << 4, 1, 2, 1);
            s_awvalid = 1'b1;
            cycle();
        end
        m_awready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_aw(i, ADDR_W'($urandom % 256) << 4, 0, 1, 1);
            cycle();
        end
        drain();

        // 4KB crossing, then clear and a burst that ends exactly at the boundary.
        set_aw(0, 32'h0000_0FF0, 7, 2, 1);
        s_awvalid = 1'b1;
        cycle();
        s_awvalid = 1'b0;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        set_aw(0, 32'h0000_0FE0, 7, 2, 1);
        s_awvalid = 1'b1;
        cycle();
        set_aw(1, 32'h0000_0FF0, 3, 3, 1);
        cycle();
        s_awvalid = 1'b0;
        drain();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        // WRAP legality: a bad length sets the flag; a good burst after clearing sets nothing.
        set_aw(0, 32'h4, 2, 2, 2);
        s_awvalid = 1'b1;
        cycle();
        s_awvalid = 1'b0;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        set_aw(0, 32'h4, 3, 2, 2);
        s_awvalid = 1'b1;
        cycle();
        s_awvalid = 1'b0;
        drain();

        // Oversize beat, reserved burst, then a clear racing a new size violation.
        set_aw(0, 32'h0, 0, 3, 1);
        s_awvalid = 1'b1;
        cycle();
        set_aw(1, 32'h0, 0, 2, 3);
        cycle();
        s_awvalid = 1'b0;
        drain();
        set_aw(0, 32'h40, 0, 3, 1);
        s_awvalid = 1'b1;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        s_awvalid = 1'b0;
        drain();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            set_aw(int'($urandom), ADDR_W'($urandom), int'($urandom % 256),
                   int'($urandom % 8), int'($urandom % 4));
            s_awvalid = 1'($urandom % 2);
            m_awready = ($urandom % 4) != 0;
            err_clr   = ($urandom % 12) == 0;
            cycle();
        end
        err_clr = 1'b0;
        drain();

        // Asynchronous reset while stalled with three entries and a sticky error.
        for (int i = 0; i < 3; i++) begin
            set_aw(i, 32'h0, 0, 3, 1);
            s_awvalid = 1'b1;
            cycle();
        end
        s_awvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_m_awvalid", 128'(m_awvalid), 128'(0));
        chk("arst_payload", 128'(m_pl), 128'(0));
        chk("arst_count", 128'(count), 128'(0));
        chk("arst_err", 128'(err), 128'(0));
        chk("arst_s_awready", 128'(s_awready), 128'(0));
        model_q.delete();
        err_m = 4'b0000;
        cycle();
        rst = 1'b0;
        cycle();
        set_aw(2, 32'h80, 0, 2, 1);
        s_awvalid = 1'b1;
        cycle();
        s_awvalid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
